// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Memory-handshake sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_e;

  // Register-file address width used by the load-use compare.
  localparam int unsigned REG_ADDR_W = 5;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Clear dominates; otherwise count up while enabled until saturated.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory handshake
// freeze, taken-branch flush, load-use stall, memory timeout and stall counter.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemRead_ex,
  input  logic [REG_ADDR_W-1:0]  RegWriteAddr_ex,
  input  logic [REG_ADDR_W-1:0]  Rs_id,
  input  logic [REG_ADDR_W-1:0]  Rt_id,
  input  logic                   UsesRt_id,
  input  logic                   BranchTaken_ex,
  input  logic                   MemRead_mem,
  input  logic                   MemWrite_mem,
  input  logic                   dmem_ready,
  output logic                   dmem_req,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_en,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   mem_wb_bubble,
  output logic                   timeout_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;

  logic memop;
  logic load_use;
  logic mem_stall;

  assign memop    = MemRead_mem | MemWrite_mem;
  assign load_use = MemRead_ex && (RegWriteAddr_ex != '0) &&
                    ((RegWriteAddr_ex == Rs_id) ||
                     (UsesRt_id && (RegWriteAddr_ex == Rt_id)));

  // Next state and pipeline controls, by priority: error, memory stall, branch, load-use.
  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    err_d         = err_q;
    dmem_req      = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    mem_stall     = 1'b0;
    if (!reset) begin
      if (state_q == ERROR) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else begin
        dmem_req  = (state_q == WAIT) | memop;
        mem_stall = dmem_req & ~dmem_ready;
        if (mem_stall) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_en     = 1'b0;
          mem_wb_bubble = 1'b1;
          if (state_q == IDLE) begin
            state_d  = WAIT;
            to_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_cnt_d == TO_W'(TIMEOUT)) begin
              state_d = ERROR;
              err_d   = 1'b1;
            end
          end
        end else begin
          // EX was frozen during the wait, so a pending branch is acted on here.
          state_d = IDLE;
          if (BranchTaken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
    end
  end

  // Sequencer state, timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign timeout_err = err_q;

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (~pc_en),
    .cnt_o (stall_cnt)
  );

endmodule
